vga_line_fetch: RTL and testbench

- Sequences pixel data from a shared frame memory into a ping-pong line buffer, one line ahead of the raster.
- Sits between the VGA timing generator (hcount/vcount/pixel_enable) and the memory port.
- Issues burst read requests over a req/gnt handshake and writes the returned beats into the back bank.
- Produces the line-buffer read address and bank for the RGB output stage.

---
 rtl/vga_line_fetch_pkg.sv | 24 ++
 rtl/vga_line_fetch.sv | 156 +++++++++++++++
 tb/tb_vga_line_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_fetch_pkg.sv
// Shared VGA timing defaults and the line-fetch FSM state type.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } fetch_state_t;

    // 1280x1024 default timing: active, front porch, sync, back porch
    localparam int HD   = 1280;
    localparam int HF   = 48;
    localparam int HR   = 112;
    localparam int HB   = 248;
    localparam int VD   = 1024;
    localparam int VF   = 1;
    localparam int VR   = 3;
    localparam int VB   = 38;
    localparam int HMAX = HD + HF + HR + HB - 1;
    localparam int VMAX = VD + VF + VR + VB - 1;

    localparam int PIX_W = 12;

endpackage

// File: rtl/vga_line_fetch.sv
// Fetches the next display line from frame memory into the back bank of a
// ping-pong line buffer while the front bank is being scanned out.
module vga_line_fetch #(
    parameter int HD         = vga_pkg::HD,
    parameter int VD         = vga_pkg::VD,
    parameter int HMAX       = vga_pkg::HMAX,
    parameter int VMAX       = vga_pkg::VMAX,
    parameter int HSYNC_BITS = 11,
    parameter int VSYNC_BITS = 11,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_W     = 21,
    parameter int PIX_W      = vga_pkg::PIX_W,
    parameter int LB_AW      = $clog2(HD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HSYNC_BITS-1:0] hcount,
    input  logic [VSYNC_BITS-1:0] vcount,
    input  logic                  pixel_enable,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [PIX_W-1:0]      mem_rdata,
    output logic                  lb_wr_en,
    output logic                  lb_wr_bank,
    output logic [LB_AW-1:0]      lb_wr_addr,
    output logic [PIX_W-1:0]      lb_wr_data,
    output logic                  pix_rd_bank,
    output logic [LB_AW-1:0]      pix_rd_addr,
    input  logic                  underrun_clr,
    output logic                  underrun,
    output logic                  fetch_busy
);
    import vga_pkg::*;

    localparam int NB   = HD / BURST_LEN;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int BT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // An inconsistent timing configuration never fetches, so the fault shows
    // up as a blank picture instead of stray memory traffic.
    localparam bit CFG_OK = (HD % BURST_LEN == 0) && (HMAX >= HD) && (VMAX >= VD);

    fetch_state_t           state;
    logic [ADDR_W-1:0]      line_base;
    logic [ADDR_W-1:0]      base_next;
    logic [BC_W-1:0]        burst_cnt;
    logic [BT_W-1:0]        beat_cnt;
    logic [VSYNC_BITS:0]    vnext;
    logic                   trig_wrap;
    logic                   trig_next;
    logic                   trigger;
    logic                   next_bank;
    logic                   beat;

    assign vnext = {1'b0, vcount} + (VSYNC_BITS + 1)'(1);

    // Trigger decode at the start of every line: wrap to line 0 after the
    // last frame line, otherwise fetch vcount+1 if it is an active line.
    always_comb begin
        trig_wrap = 1'b0;
        trig_next = 1'b0;
        base_next = line_base;
        if (CFG_OK && hcount == '0) begin
            if (vcount == VSYNC_BITS'(VMAX)) begin
                trig_wrap = 1'b1;
                base_next = '0;
            end else if (32'(vnext) < VD) begin
                trig_next = 1'b1;
                base_next = line_base + ADDR_W'(HD);
            end
        end
    end

    assign trigger    = trig_wrap | trig_next;
    assign next_bank  = trig_next & ~vcount[0];
    assign fetch_busy = (state != IDLE);
    assign beat       = (state == DATA) && mem_rvalid;

    // Returned beats go straight into the line buffer in the same cycle.
    assign lb_wr_en   = beat;
    assign lb_wr_data = beat ? mem_rdata : '0;
    assign lb_wr_addr = beat ? LB_AW'(burst_cnt) * LB_AW'(BURST_LEN) + LB_AW'(beat_cnt) : '0;

    // Frame-aligned line base, sticky underrun flag and display-side read port.
    // line_base advances on every trigger, even a dropped one.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_base   <= '0;
            underrun    <= 1'b0;
            pix_rd_bank <= 1'b0;
            pix_rd_addr <= '0;
        end else begin
            if (trigger) begin
                line_base <= base_next;
            end
            if (trigger && state != IDLE) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            pix_rd_bank <= vcount[0];
            pix_rd_addr <= pixel_enable ? hcount[LB_AW-1:0] : '0;
        end
    end

    // Burst sequencer: one outstanding burst, request held until granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            lb_wr_bank <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state      <= REQ;
                        burst_cnt  <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= base_next;
                        lb_wr_bank <= next_bank;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state    <= DATA;
                        mem_req  <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (mem_rvalid) begin
                        if (beat_cnt == BT_W'(BURST_LEN - 1)) begin
                            if (burst_cnt == BC_W'(NB - 1)) begin
                                state <= IDLE;
                            end else begin
                                state     <= REQ;
                                burst_cnt <= burst_cnt + 1'b1;
                                mem_req   <= 1'b1;
                                mem_addr  <= mem_addr + ADDR_W'(BURST_LEN);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch on a reduced 32x4 raster. Expected
// requests and line-buffer writes are queued by the stimulus and consumed by
// a monitor whenever the DUT shows a grant handshake or a write strobe.
module tb_vga_line_fetch;

    localparam int HD   = 32;
    localparam int VD   = 4;
    localparam int HMAX = 47;
    localparam int VMAX = 6;
    localparam int BL   = 8;
    localparam int AW   = 21;
    localparam int PW   = 12;
    localparam int LAW  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [10:0]    hcount;
    logic [10:0]    vcount;
    logic           pixel_enable;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [PW-1:0]  mem_rdata;
    logic           lb_wr_en;
    logic           lb_wr_bank;
    logic [LAW-1:0] lb_wr_addr;
    logic [PW-1:0]  lb_wr_data;
    logic           pix_rd_bank;
    logic [LAW-1:0] pix_rd_addr;
    logic           underrun_clr;
    logic           underrun;
    logic           fetch_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int gnt_delay_once = 0;
    int rv_gap = 0;

    logic [AW-1:0] exp_req[$];
    logic [17:0]   exp_wr[$];   // {bank, lb addr, data}

    vga_line_fetch #(
        .HD(HD), .VD(VD), .HMAX(HMAX), .VMAX(VMAX), .HSYNC_BITS(11), .VSYNC_BITS(11),
        .BURST_LEN(BL), .ADDR_W(AW), .PIX_W(PW), .LB_AW(LAW)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .pixel_enable(pixel_enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .lb_wr_en(lb_wr_en), .lb_wr_bank(lb_wr_bank),
        .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .pix_rd_bank(pix_rd_bank),
        .pix_rd_addr(pix_rd_addr), .underrun_clr(underrun_clr), .underrun(underrun),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected traffic for one full line fetch; memory data equals the pixel address.
    task automatic push_line(input int base, input bit bank);
        for (int b = 0; b < HD / BL; b++) exp_req.push_back(AW'(base + b * BL));
        for (int i = 0; i < HD; i++) exp_wr.push_back({bank, LAW'(i), PW'(base + i)});
    endtask

    task automatic run_line(input int v);
        for (int h = 0; h <= HMAX; h++) begin
            @(posedge clk); #1;
            hcount       = 11'(h);
            vcount       = 11'(v);
            pixel_enable = (h < HD) && (v < VD);
        end
    endtask

    task automatic end_line_chk(input string tag);
        @(negedge clk);
        chk({tag, "_req_left"}, 64'(exp_req.size()), 0);
        chk({tag, "_wr_left"}, 64'(exp_wr.size()), 0);
        chk({tag, "_busy"}, 64'(fetch_busy), 0);
    endtask

    // Memory port model: optional one-shot grant delay, rvalid throttle,
    // keeps returning beats of a burst even if the DUT is reset meanwhile.
    initial begin
        int wait_cnt, m_beats, m_cnt, gcnt;
        logic [AW-1:0] m_addr, addr_s;
        logic req_s, gnt_s;
        wait_cnt = 0; m_beats = 0; m_cnt = 0; gcnt = 0; m_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 12'hBAD;
        forever begin
            @(negedge clk);
            req_s = mem_req; gnt_s = mem_gnt; addr_s = mem_addr;
            @(posedge clk); #1;
            if (req_s && gnt_s) begin
                m_addr = addr_s; m_beats = BL; m_cnt = 0; gcnt = 0; gnt_delay_once = 0;
            end
            if (mem_req && wait_cnt < gnt_delay_once) begin
                mem_gnt = 1'b0;
                wait_cnt++;
            end else begin
                mem_gnt = 1'b1;
                if (!mem_req) wait_cnt = 0;
            end
            mem_rvalid = 1'b0;
            mem_rdata  = 12'hBAD;
            if (m_beats > 0) begin
                if (gcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = PW'(m_addr + AW'(m_cnt));
                    m_cnt++; m_beats--; gcnt = rv_gap;
                end else begin
                    gcnt--;
                end
            end
        end
    end

    // Monitor: grants, request hold, line-buffer writes and read-port registers.
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic          prev_rst  = 1'b1;
    logic          prev_pe   = 1'b0;
    logic [10:0]   prev_h    = '0;
    logic [10:0]   prev_v    = '0;
    always @(negedge clk) begin
        if (mem_req && mem_gnt) begin
            if (exp_req.size() == 0) chk("req_unexpected", 64'(mem_addr), 64'(exp_req.size()) + 1);
            else chk("req_addr", 64'(mem_addr), 64'(exp_req.pop_front()));
        end
        if (hold_pend && !prev_rst) chk("req_hold", {mem_req, mem_addr}, {1'b1, hold_addr});
        hold_pend = mem_req && !mem_gnt && !rst;
        hold_addr = mem_addr;
        if (lb_wr_en) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", {lb_wr_bank, lb_wr_addr, lb_wr_data}, 64'(exp_wr.size()) + 1);
            else chk("lb_write", {lb_wr_bank, lb_wr_addr, lb_wr_data}, 64'(exp_wr.pop_front()));
        end
        chk("pix_rd_addr", 64'(pix_rd_addr), (prev_rst || !prev_pe) ? 64'd0 : 64'(prev_h[LAW-1:0]));
        chk("pix_rd_bank", 64'(pix_rd_bank), prev_rst ? 64'd0 : 64'(prev_v[0]));
        prev_rst = rst; prev_pe = pixel_enable; prev_h = hcount; prev_v = vcount;
    end

    initial begin
        rst = 1'b1; hcount = 11'd5; vcount = 11'd6; pixel_enable = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem", {mem_req, mem_addr, underrun, fetch_busy}, 0);
        chk("reset_lb", {lb_wr_en, lb_wr_bank, lb_wr_addr, lb_wr_data, pix_rd_bank, pix_rd_addr}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // wrap to line 0: base 0, bank 0
        push_line(0, 1'b0);  run_line(6); end_line_chk("line0");
        // line 1 with a 5-cycle grant delay on the first burst: base 32, bank 1
        gnt_delay_once = 5;
        push_line(32, 1'b1); run_line(0); end_line_chk("line1");
        push_line(64, 1'b0); run_line(1); end_line_chk("line2");
        push_line(96, 1'b1); run_line(2); end_line_chk("line3");
        // last active line and blanking: no fetch
        run_line(3); end_line_chk("nofetch3");
        run_line(4); run_line(5);
        chk("underrun_before", 64'(underrun), 0);

        // throttled fetch of line 0 overruns into the next line time
        rv_gap = 1;
        push_line(0, 1'b0); run_line(6);
        @(negedge clk);
        chk("slow_still_busy", 64'(fetch_busy), 1);
        run_line(0); end_line_chk("slow_line0");
        chk("underrun_set", 64'(underrun), 1);
        rv_gap = 0;
        // line 1 was dropped; line 2 still lands at base 2*HD
        push_line(64, 1'b0); run_line(1); end_line_chk("after_drop");
        chk("underrun_sticky", 64'(underrun), 1);
        @(posedge clk); #1 underrun_clr = 1'b1;
        @(posedge clk); #1 underrun_clr = 1'b0;
        @(negedge clk);
        chk("underrun_cleared", 64'(underrun), 0);

        // reset while beat 3 of the first burst of line 3 is being written
        exp_req.push_back(AW'(96));
        for (int i = 0; i < 4; i++) exp_wr.push_back({1'b1, LAW'(i), PW'(96 + i)});
        fork
            run_line(2);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    if (lb_wr_en && lb_wr_bank && lb_wr_addr == LAW'(2)) seen = 1'b1;
                end
                if (!seen) begin
                    n_chk++; n_fail++;
                    $display("FAIL rst_wait: beat 2 of line 3 not seen within 40 cycles");
                end else begin
                    @(posedge clk); #1 rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    chk("midrst_mem", {mem_req, mem_addr, underrun, fetch_busy}, 0);
                    chk("midrst_lb", {lb_wr_en, lb_wr_bank, lb_wr_addr, lb_wr_data, pix_rd_bank, pix_rd_addr}, 0);
                    @(posedge clk); #1 rst = 1'b0;
                end
            end
        join
        end_line_chk("rst_line3");
        run_line(3); run_line(4); run_line(5);
        push_line(0, 1'b0); run_line(6); end_line_chk("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
